// File: rtl/tile_spawn_controller_if.sv
// tile_spawn_controller_if: spawn request, generator handshake and board write-back bundle.
interface tile_spawn_controller_if;
  logic        spawn_req;
  logic [63:0] board_in;
  logic [15:0] empty_mask;
  logic        gen_req;
  logic        gen_valid;
  logic [3:0]  gen_pos;
  logic [4:0]  gen_val;
  logic [63:0] board_out;
  logic        board_we;
  logic        busy;
  logic        spawn_done;
  logic        no_space;
  modport master (
    input  spawn_req, board_in, gen_valid, gen_pos, gen_val,
    output empty_mask, gen_req, board_out, board_we, busy, spawn_done, no_space
  );
  modport slave (
    output spawn_req, board_in, gen_valid, gen_pos, gen_val,
    input  empty_mask, gen_req, board_out, board_we, busy, spawn_done, no_space
  );
endinterface

// File: rtl/tile_spawn_controller.sv
// tile_spawn_controller: inserts a generator-picked tile into an empty cell of the 2048 board.
// SPAWN_FALLBACK_EN adds a linear probe after MAX_RETRY occupied picks.
module tile_spawn_controller #(
  parameter int MAX_RETRY = 8,
  parameter int RETRY_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  tile_spawn_controller_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, SCAN, REQ, WAIT, CHECK, WRITE
`ifdef SPAWN_FALLBACK_EN
    , PROBE
`endif
  } state_t;
  state_t              state_q, state_d;
  logic [63:0]         board_q, board_d, out_q, out_d;
  logic [15:0]         mask_q, mask_d, scan_mask;
  logic [3:0]          pos_q, pos_d, val_q, val_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                no_space_q, no_space_d, done_q, done_d, req_q, we_q, busy_q;
  always_comb
    for (int i = 0; i < 16; i++) scan_mask[i] = board_q[4*i +: 4] == 4'h0;
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    mask_d     = mask_q;
    pos_d      = pos_q;
    val_d      = val_q;
    retry_d    = retry_q;
    no_space_d = no_space_q;
    out_d      = out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.spawn_req) begin
        board_d    = bus.board_in;
        no_space_d = 1'b0;
        retry_d    = '0;
        state_d    = SCAN;
      end
      SCAN: begin
        mask_d     = scan_mask;
        no_space_d = scan_mask == 16'h0;
        done_d     = scan_mask == 16'h0;
        state_d    = scan_mask == 16'h0 ? IDLE : REQ;
      end
      REQ: state_d = WAIT;
      WAIT: if (bus.gen_valid) begin
        pos_d   = bus.gen_pos;
        val_d   = (bus.gen_val == 5'd1 || bus.gen_val == 5'd2) ? bus.gen_val[3:0] : 4'h1;
        state_d = CHECK;
      end
      CHECK: if (mask_q[pos_q]) state_d = WRITE;
      else begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = REQ;
`ifdef SPAWN_FALLBACK_EN
        if (retry_d == RETRY_W'(MAX_RETRY)) state_d = PROBE;
`else
        if (retry_d == RETRY_W'(MAX_RETRY)) retry_d = '0;
`endif
      end
`ifdef SPAWN_FALLBACK_EN
      PROBE: begin
        pos_d   = pos_q + 4'd1;
        state_d = mask_q[pos_d] ? WRITE : PROBE;
      end
`endif
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Insert one cycle early so board_out is valid alongside board_we
    if (state_d == WRITE) begin
      done_d = 1'b1;
      out_d  = (board_q & ~(64'hF << {pos_d, 2'b00})) | ({60'h0, val_d} << {pos_d, 2'b00});
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      board_q    <= '0;
      mask_q     <= '0;
      pos_q      <= '0;
      val_q      <= '0;
      retry_q    <= '0;
      no_space_q <= 1'b0;
      out_q      <= '0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      mask_q     <= mask_d;
      pos_q      <= pos_d;
      val_q      <= val_d;
      retry_q    <= retry_d;
      no_space_q <= no_space_d;
      out_q      <= out_d;
      done_q     <= done_d;
      req_q      <= state_d == REQ;
      we_q       <= state_d == WRITE;
      busy_q     <= state_d != IDLE;
    end
  assign bus.empty_mask = mask_q;
  assign bus.gen_req    = req_q;
  assign bus.board_out  = out_q;
  assign bus.board_we   = we_q;
  assign bus.busy       = busy_q;
  assign bus.spawn_done = done_q;
  assign bus.no_space   = no_space_q;
endmodule

// File: tb/tb_tile_spawn_controller.sv
// tb_tile_spawn_controller: cycle vectors for the basic spawn paths plus retry and reset sequences.
module tb_tile_spawn_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  tile_spawn_controller_if bus();
  tile_spawn_controller #(.MAX_RETRY(8), .RETRY_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  wire [84:0] obs = {bus.empty_mask, bus.gen_req, bus.board_we, bus.busy, bus.spawn_done, bus.no_space, bus.board_out};
  typedef struct {
    logic        spawn;
    logic [63:0] board;
    logic        gv;
    logic [3:0]  gp;
    logic [4:0]  gval;
    logic [15:0] mask;
    logic [4:0]  flags;
    logic [63:0] bout;
  } vec_t;
  vec_t v[18];
  task automatic check(input string name, input logic [84:0] act, input logic [84:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  localparam logic [63:0] B1 = 64'h0000_0000_0020_0000;
  localparam logic [63:0] F1 = 64'h1111_1111_1111_1111;
  initial begin
    int nreq, nwe, last_v, we_cyc;
    logic req_last;
    logic [63:0] wout;
    bus.spawn_req = 1'b0;
    bus.board_in  = '0;
    bus.gen_valid = 1'b0;
    bus.gen_pos   = '0;
    bus.gen_val   = '0;
    // flags = {gen_req, board_we, busy, spawn_done, no_space}
    v[0]  = '{1'b1, 64'h0, 1'b0, 4'd0, 5'd0, 16'h0000, 5'b00000, 64'h0};
    v[1]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'h0000, 5'b00100, 64'h0};
    v[2]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'hFFFF, 5'b10100, 64'h0};
    v[3]  = '{1'b0, 64'h0, 1'b1, 4'd5, 5'd2, 16'hFFFF, 5'b00100, 64'h0};
    v[4]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'hFFFF, 5'b00100, 64'h0};
    v[5]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'hFFFF, 5'b01110, B1};
    v[6]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'hFFFF, 5'b00000, B1};
    v[7]  = '{1'b1, F1,    1'b0, 4'd0, 5'd0, 16'hFFFF, 5'b00000, B1};
    v[8]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'hFFFF, 5'b00100, B1};
    v[9]  = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0, 16'h0000, 5'b00011, B1};
    v[10] = '{1'b1, 64'h1111_1111_1111_1011, 1'b0, 4'd0, 5'd0, 16'h0000, 5'b00001, B1};
    v[11] = '{1'b1, 64'h0, 1'b0, 4'd0, 5'd0,    16'h0000, 5'b00100, B1};
    v[12] = '{1'b1, 64'h0, 1'b0, 4'd0, 5'd0,    16'h0004, 5'b10100, B1};
    v[13] = '{1'b1, 64'h0, 1'b1, 4'd2, 5'h1F,   16'h0004, 5'b00100, B1};
    v[14] = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0,    16'h0004, 5'b00100, B1};
    v[15] = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0,    16'h0004, 5'b01110, F1};
    v[16] = '{1'b0, 64'h0, 1'b1, 4'd0, 5'd2,    16'h0004, 5'b00000, F1};
    v[17] = '{1'b0, 64'h0, 1'b0, 4'd0, 5'd0,    16'h0004, 5'b00000, F1};
    repeat (2) @(negedge clk);
    check("reset_state", obs, 85'h0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      check($sformatf("vec%0d", i), obs, {v[i].mask, v[i].flags, v[i].bout});
      bus.spawn_req = v[i].spawn;
      bus.board_in  = v[i].board;
      bus.gen_valid = v[i].gv;
      bus.gen_pos   = v[i].gp;
      bus.gen_val   = v[i].gval;
      @(negedge clk);
    end
    bus.spawn_req = 1'b0;
    bus.gen_valid = 1'b0;
    // Only cell 0 empty; generator keeps picking occupied cell 3
    bus.spawn_req = 1'b1;
    bus.board_in  = 64'h1111_1111_1111_1110;
    @(negedge clk);
    bus.spawn_req = 1'b0;
    nreq = 0; nwe = 0; last_v = 0; we_cyc = 0; req_last = 1'b0; wout = '0;
    for (int c = 1; c <= 300; c++) begin
      if (bus.board_we) begin
        nwe++;
        we_cyc = c;
        wout = bus.board_out;
        break;
      end
      bus.gen_valid = req_last;
      bus.gen_val   = 5'd2;
`ifdef SPAWN_FALLBACK_EN
      bus.gen_pos   = 4'd3;
`else
      bus.gen_pos   = nreq >= 13 ? 4'd0 : 4'd3;
`endif
      if (req_last) last_v = c;
      if (bus.gen_req) nreq++;
      req_last = bus.gen_req;
      @(negedge clk);
    end
    bus.gen_valid = 1'b0;
    check("retry_we_count", 85'(nwe), 85'd1);
    check("retry_board_out", 85'(wout), 85'(64'h1111_1111_1111_1112));
`ifdef SPAWN_FALLBACK_EN
    check("retry_gen_reqs", 85'(nreq), 85'd8);
    check("probe_latency", 85'(we_cyc - last_v), 85'd15);
`else
    check("retry_gen_reqs", 85'(nreq), 85'd13);
    check("hit_latency", 85'(we_cyc - last_v), 85'd2);
`endif
    @(negedge clk);
    // Reset asserted while waiting on the generator
    bus.spawn_req = 1'b1;
    bus.board_in  = '0;
    @(negedge clk);
    bus.spawn_req = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_busy", 85'(bus.busy), 85'd1);
    #2 rst = 1'b0;
    #1 check("async_reset", obs, 85'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.gen_valid = 1'b1;
    bus.gen_pos   = 4'd5;
    bus.gen_val   = 5'd2;
    @(negedge clk);
    bus.gen_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_reset%0d", k), obs, 85'h0);
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tile_spawn_controller.md
Name: tile_spawn_controller

Overview:
- Downstream consumer of the new-tile generator in the 2048 datapath.
- After each accepted move, it derives the 16-bit empty-cell mask from the board and requests a random position/value from the generator.
- It rejects positions that are already occupied, retrying a bounded number of times, then inserts the tile and returns the updated board to the board register.
- It flags game-over-for-spawn when no empty cell exists.

Parameters:
- MAX_RETRY, 8: generator misses tolerated before the fallback probe (1..15).
- RETRY_W, 4: width of the retry counter; must hold MAX_RETRY.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous reset, active-low (0 = reset).
- spawn_req, input, 1: one-cycle pulse, move accepted and a spawn is wanted.
- board_in, input, 64: 16 cells × 4-bit exponent; cell i = bits [4i+3:4i]; 0 = empty.
- empty_mask, output, 16: registered; bit i = 1 when cell i is empty; drives the generator.
- gen_req, output, 1: one-cycle pulse asking the generator for a new pick.
- gen_valid, input, 1: generator pick valid this cycle.
- gen_pos, input, 4: picked cell index.
- gen_val, input, 5: tile preset; 1 = tile 2, 2 = tile 4.
- board_out, output, 64: board with the new tile inserted.
- board_we, output, 1: one-cycle write strobe for board_out.
- busy, output, 1: high outside IDLE.
- spawn_done, output, 1: one-cycle pulse when the spawn completes (written or no space).
- no_space, output, 1: sticky; set when a spawn finds the mask all-zero; cleared by the next spawn_req.

Behaviour:
- Reset (rst = 0, any time, including mid-operation):
  - FSM goes to IDLE; retry counter = 0.
  - All outputs = 0 (empty_mask, board_out, gen_req, board_we, busy, spawn_done, no_space).
  - Pending gen_valid is ignored.
- States and transitions:
  - IDLE: on spawn_req, latch board_in into board_q, clear no_space, go to SCAN. spawn_req outside IDLE is ignored.
  - SCAN (1 cycle): register empty_mask from board_q.
    - Mask == 0: set no_space, pulse spawn_done, go to IDLE.
    - Otherwise go to REQ.
  - REQ (1 cycle): pulse gen_req, go to WAIT.
  - WAIT: hold until gen_valid. Latch pos_q = gen_pos and val_q = gen_val, go to CHECK. There is no timeout.
  - CHECK:
    - If empty_mask[pos_q] = 1, go to WRITE.
    - Else increment retry. If retry reaches MAX_RETRY, go to PROBE (macro on) or go to REQ with retry cleared (macro off). Otherwise go to REQ.
  - PROBE: each cycle pos_q = pos_q + 1 (mod 16, wrap 15 → 0). Go to WRITE when empty_mask at the new pos_q = 1. At most 15 cycles, guaranteed to terminate because mask ≠ 0.
  - WRITE (1 cycle): board_out = board_q with cell pos_q replaced by val_q[3:0]. board_we = 1 and spawn_done = 1 together. Go to IDLE.
- Value rule: val_q values other than 1 or 2 are clamped to 1.
- Best-case latency: spawn_req at cycle 0, SCAN at 1, gen_req at 2, gen_valid at 3, CHECK at 4, board_we at 5.
- gen_valid arriving outside WAIT is ignored.
- board_out holds its last written value between writes.
- board_in may change while busy; only board_q is used.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: SPAWN_FALLBACK_EN.
- Defined: the PROBE state exists; after MAX_RETRY occupied picks, a linear probe from pos_q+1 with wrap guarantees bounded completion.
- Undefined: PROBE is removed; after MAX_RETRY misses the counter clears and the controller keeps requesting from the generator until it hits an empty cell. Completion time is then unbounded.

Test Plan:
- Empty board (board_in = 0), spawn_req, generator returns pos = 5, val = 2 on the first gen_req → empty_mask = 16'hFFFF, board_we at cycle 5, board_out = 64'h0000_0000_0020_0000, spawn_done coincident, no_space = 0.
- Full board (all cells = 4'h1), spawn_req → empty_mask = 0, spawn_done one cycle after SCAN, no_space = 1, board_we never asserted, gen_req never asserted.
- Only cell 0 empty, generator always returns pos = 3, MAX_RETRY = 8, macro on → 8 gen_req pulses, then PROBE wraps 4 … 15 → 0. board_out cell 0 = val, all other cells unchanged.
- Same stimulus, macro off → gen_req keeps pulsing past 8 with no board_we; generator then returns pos = 0 → write to cell 0.
- rst driven low while in WAIT, then released, then a stray gen_valid → all outputs 0, FSM in IDLE, no board_we.
- spawn_req pulsed again while busy, and gen_val = 5'h1F → second request ignored (only one spawn_done), written cell value = 4'h1.
